// File: rtl/taxi_pkg.sv
// taxi_pkg: shared types and constants for the taxi fare codebase
package taxi_pkg;
    localparam int FEE_W = 16;
    localparam int BCD_W = 4;
    localparam logic [FEE_W-1:0] FEE_MAX_DEF = 16'd9999;
    typedef enum logic [1:0] {FREE = 2'd0, CHARGE = 2'd1, FULL = 2'd2} wait_state_t;
endpackage

// File: rtl/bcd_cnt2.sv
// bcd_cnt2: two-digit BCD counter, saturates at 99, sync clear
module bcd_cnt2
    import taxi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] ones,
    output logic [BCD_W-1:0] tens
);
    logic at_max;
    assign at_max = (ones == 4'd9) && (tens == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= '0;
            tens <= '0;
        end else if (clr) begin
            ones <= '0;
            tens <= '0;
        end else if (inc && !at_max) begin
            ones <= (ones == 4'd9) ? '0 : ones + 4'd1;
            tens <= (ones == 4'd9) ? tens + 4'd1 : tens;
        end
    end
endmodule

// File: rtl/wait_fee_acc.sv
// wait_fee_acc: turns minute square wave into ticks, counts waiting minutes
// in BCD and accumulates a saturating waiting fee after a free allowance
module wait_fee_acc
    import taxi_pkg::*;
#(
    parameter logic [7:0]       FREE_MIN = 8'd3,
    parameter logic [FEE_W-1:0] WAIT_FEE = 16'd10,
    parameter logic [FEE_W-1:0] FEE_MAX  = FEE_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             min_pulse,
    input  logic             en,
    input  logic             clr,
    input  logic             max_in,
    output logic             minute_tick,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic [FEE_W-1:0] wait_fee,
    output logic             wait_max
);
    localparam wait_state_t INIT_ST = (FREE_MIN == 8'd0) ? CHARGE : FREE;

    wait_state_t      state;
    logic             pulse_d;
    logic [7:0]       free_cnt;
    logic             rise;
    logic             acc;
    logic [FEE_W:0]   sum;

    assign rise = min_pulse & ~pulse_d;
    assign acc  = rise & en & ~max_in & ~clr & (state != FULL);
    assign sum  = {1'b0, wait_fee} + {1'b0, WAIT_FEE};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_d     <= 1'b0;
            minute_tick <= 1'b0;
            free_cnt    <= '0;
            wait_fee    <= '0;
            wait_max    <= 1'b0;
            state       <= INIT_ST;
        end else begin
            pulse_d     <= min_pulse;
            minute_tick <= acc;
            if (clr) begin
                free_cnt <= '0;
                wait_fee <= '0;
                wait_max <= 1'b0;
                state    <= INIT_ST;
            end else if (acc) begin
                case (state)
                    FREE: begin
                        free_cnt <= free_cnt + 8'd1;
                        if (free_cnt + 8'd1 == FREE_MIN)
                            state <= CHARGE;
                    end
                    CHARGE: begin
                        // Widened sum so the ceiling compare cannot wrap
                        if (sum >= {1'b0, FEE_MAX}) begin
                            wait_fee <= FEE_MAX;
                            wait_max <= 1'b1;
                            state    <= FULL;
                        end else begin
                            wait_fee <= sum[FEE_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    bcd_cnt2 u_min (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (acc),
        .ones (min_ones),
        .tens (min_tens)
    );
endmodule

// File: doc/wait_fee_acc.md
Name: wait_fee_acc

Overview:
Consumer end of the minute-pulse interface. Takes the square-wave min_pulse from the divider (one full period per minute) and converts each rising edge into a one-cycle minute tick. It counts waiting minutes in BCD for the display and applies a free-minute allowance. It accumulates a saturating waiting fee for the fare logic and raises wait_max back toward the fare path when the fee ceiling is hit.

Parameters:
FREE_MIN, 8'd3, number of leading waiting minutes not charged (0 = charge from first minute)
WAIT_FEE, 16'd10, fee added per charged minute (0.1-yuan units)
FEE_MAX, 16'd9999, waiting-fee ceiling (0.1-yuan units)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset: asynchronous, active-low
min_pulse  in  1  minute square wave from divider, synchronous to clk; rising edge = one minute
en  in  1  waiting mode active (vehicle stopped, trip in progress)
clr  in  1  synchronous clear at start of a new trip
max_in  in  1  total-fare saturation from fee_total; freezes accumulation
minute_tick  out  1  one-cycle pulse per accepted minute
min_ones  out  4  waiting minutes, BCD ones digit
min_tens  out  4  waiting minutes, BCD tens digit
wait_fee  out  16  accumulated waiting fee, binary
wait_max  out  1  wait_fee has reached FEE_MAX

Behaviour:
- Reset values: all outputs 0, pulse_d=0, free_cnt=0, state=FREE (CHARGE if FREE_MIN==0).
- Edge detect: pulse_d <= min_pulse every cycle, regardless of en. rise = min_pulse & ~pulse_d.
- Accept: acc = rise & en & ~max_in & ~clr & (state!=FULL).
- minute_tick is registered and high exactly one cycle, the cycle after the edge that sampled rise with acc=1. Counters and fee update on that same edge, so they are visible in the same cycle as minute_tick.
- Rising edges with acc=0 are discarded, not queued. en low or max_in high holds every count.
- Minutes: BCD increment on acc. Ones 9 -> 0 with a carry into tens. Saturate at 99; a tick at 99 is still emitted but the digits hold.
- States:
  - FREE: on acc, free_cnt++. When free_cnt+1==FREE_MIN, go to CHARGE. That minute is free and wait_fee is unchanged.
  - CHARGE: on acc, sum = wait_fee + WAIT_FEE computed 17 bits wide.
    - If sum >= FEE_MAX: wait_fee=FEE_MAX, wait_max=1, go to FULL.
    - Otherwise wait_fee=sum.
  - FULL: terminal until clr or reset. No ticks, minutes and fee frozen, wait_max held 1.
- clr (synchronous, highest priority after reset):
  - zeroes minutes, fee, free_cnt and wait_max, returns to the initial state, suppresses minute_tick that cycle.
  - clr coincident with rise: clr wins and the edge is lost.
  - pulse_d still updates, so no phantom edge after clr.
- Reset mid-operation: immediate asynchronous return to reset values. The first rise after deassertion is counted normally.
- Legal parameter constraints: WAIT_FEE <= FEE_MAX, FEE_MAX < 2^16.

Decomposition:
- Shared taxi_pkg holds:
  - state encoding FREE/CHARGE/FULL (2 bits)
  - fee width constant FEE_W=16
  - BCD digit width 4
  - FEE_MAX default, shared with fee_total
- One sub-module, bcd_cnt2: two-digit saturating BCD counter with inc/clr. It is reusable for the distance display.
- Edge detect and FSM stay inline.

Test Plan:
- Bench parameters FREE_MIN=2, WAIT_FEE=10, FEE_MAX=35, en=1. Six min_pulse rising edges produce:
  - 6 minute_tick pulses
  - wait_fee sequence 0,0,10,20,30,35
  - wait_max=1 after the 6th tick, digits 0/6
  - a 7th edge gives no tick
- Hold min_pulse high for 100 cycles -> exactly one minute_tick. A toggling pulse with en=0 -> no ticks, outputs unchanged.
- FEE_MAX=16'd9999, 99 edges then a 100th -> digits 9/9 at edge 99 and held at 9/9 after edge 100. Between edges 9 and 10, digits go 0/9 -> 1/0.
- clr asserted on the same cycle as a rise with wait_fee=20 -> wait_fee=0, digits 0/0, no minute_tick. The next edge is counted as free minute 1.
- max_in=1 across 3 edges -> no ticks, no change. Deassert max_in, next edge counts.
- rst_n pulsed low mid-CHARGE with wait_fee=20 -> all outputs 0 asynchronously. FREE_MIN=0 build -> first edge gives wait_fee=10.
